// File: rtl/serial_mersenne_adder.sv
// serial_mersenne_adder
//   Bit-serial adder, LSB first, one full-adder evaluation per clock with a
//   registered carry. mode=0 gives a plain WIDTH-bit sum plus carry-out.
//   mode=1 gives the sum modulo 2^WIDTH-1: an end-around carry is folded back
//   in by a second serial pass, and an all-ones result is mapped to 0.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands/mode valid          in_ready  high only while idle
//   a, b       WIDTH-bit operands           mode      0 plain, 1 mod 2^W-1
//   out_valid  result/carry_out valid       out_ready consumer accepts result
//   result     sum or canonical residue     carry_out plain-mode carry (0 in mode 1)
//   busy       high from accept until the result handshake
module serial_mersenne_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_WRAP,
        S_FIN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             mode_r;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             op_x, op_y;
    logic             sum_bit, carry_nxt;
    logic             last_bit, accept, release_res;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    assign in_ready    = (state == S_IDLE);
    assign accept      = in_valid && in_ready;
    assign release_res = (state == S_DONE) && out_valid && out_ready;
    assign last_bit    = (cnt == LAST_BIT);
    assign result      = res_sr;

    // The single full-adder cell. In WRAP the result register feeds itself
    // back through the A input while B is tied to 0, so the preloaded carry
    // acts as the +1 at the LSB.
    always_comb begin
        op_x = a_sr[0];
        op_y = b_sr[0];
        if (state == S_WRAP) begin
            op_x = res_sr[0];
            op_y = 1'b0;
        end
        sum_bit   = fa_sum(op_x, op_y, carry);
        carry_nxt = fa_carry(op_x, op_y, carry);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ADD;
            S_ADD:   if (last_bit) state_nxt = (mode_r && carry_nxt) ? S_WRAP : S_FIN;
            S_WRAP:  if (last_bit) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_DONE;
            S_DONE:  if (release_res) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            mode_r    <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        mode_r <= mode;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                S_ADD: begin
                    res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    // WRAP is only entered when carry_nxt is 1, so keeping
                    // carry_nxt here is also the carry preload for the wrap pass.
                    carry  <= carry_nxt;
                    cnt    <= last_bit ? '0 : cnt + CNT_W'(1);
                end
                S_WRAP: begin
                    // (2^N-2)+1 never overflows, so the final carry is dropped.
                    res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
                    carry  <= carry_nxt;
                    cnt    <= last_bit ? '0 : cnt + CNT_W'(1);
                end
                S_FIN: begin
                    if (mode_r) begin
                        carry_out <= 1'b0;
                        // All-ones is the redundant encoding of zero mod 2^N-1.
                        if (&res_sr) res_sr <= '0;
                    end else begin
                        carry_out <= carry;
                    end
                    out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (release_res) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_mersenne_adder.md
Name: serial_mersenne_adder

Overview:
- Parametrised bit-serial adder that adds two WIDTH-bit operands LSB-first, one bit per clock, through an internal full-adder cell with a registered carry.
- Two modes:
  - Plain binary add, producing an N-bit sum and a carry-out.
  - Addition modulo the Mersenne number 2^WIDTH-1, using an end-around-carry second pass and canonical-zero output.
- Sits in the Mersenne arithmetic datapath as the area-cheap modular add primitive, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits (N); legal range 2..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/mode valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mode  input  1  0 = plain add; 1 = add mod 2^WIDTH-1.
- out_valid  output  1  result/carry_out valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum (plain) or canonical residue (mode 1).
- carry_out  output  1  final carry in plain mode; always 0 in mode 1.
- busy  output  1  high from accept until out_valid&&out_ready.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - result, carry_out, out_valid, busy, internal shift registers, carry flop and bit counter all clear to 0.
  - in_ready goes to 1 immediately (combinational from state==IDLE).
- States: IDLE, ADD, WRAP, FIN, DONE.
- IDLE:
  - On edge k with in_valid&&in_ready: latch a, b and mode into shift registers.
  - Clear the carry flop and counter; go to ADD; busy=1.
- ADD:
  - Each edge computes s = a0^b0^c and c' = majority(a0,b0,c).
  - s is shifted into the result register at the MSB side, right-shifting.
  - Operand registers shift right; the counter increments.
  - After WIDTH edges (edge k+WIDTH), the full N-bit sum is in the result register and the carry flop holds bit N.
  - Next state: WRAP if mode=1 and carry=1; otherwise FIN.
- WRAP:
  - Second serial pass adds the stored carry (as a 1 at LSB) to the result register.
  - The b path is fed with 0; the carry flop is preloaded with 1 and the counter reset on entry.
  - Takes WIDTH edges.
  - Arithmetic guarantees no carry out of WRAP (max (2^N-2)+1); carry is discarded.
- FIN (1 edge):
  - Mode 0: carry_out = stored carry.
  - Mode 1: if result == all-ones, force result to 0 (canonical residue); carry_out=0.
  - Set out_valid; go to DONE.
- Latency from accept edge k to out_valid high:
  - After edge k+WIDTH+1 when there is no wrap.
  - After edge k+2*WIDTH+1 when there is a wrap.
- DONE:
  - result, carry_out and out_valid are held stable until out_valid&&out_ready.
  - On that edge: out_valid=0, busy=0, go to IDLE.
  - in_ready rises in the following cycle; there is no same-cycle re-accept.
- in_valid outside IDLE is ignored; input operands are not sampled after accept.
- out_ready outside DONE is ignored.
- Reset mid-ADD/WRAP/DONE aborts the operation with no output; the next accepted operation is unaffected.
- Inputs a/b may be all-ones in either mode; both all-ones in mode 1 gives 0 via WRAP then FIN canonicalisation.

Test Plan:
- WIDTH=8, mode 0, a=55, b=17, out_ready=1 -> result=0x48 (72), carry_out=0; out_valid after edge k+9; busy high k..k+10.
- WIDTH=8, mode 0, a=200, b=100 -> result=0x2C (44), carry_out=1. Same operands in mode 1 -> WRAP taken, result=45 (300 mod 255), carry_out=0, out_valid after edge k+17.
- WIDTH=8, mode 1, a=128, b=127 -> no wrap, all-ones canonicalised, result=0 at k+9. a=255, b=255 -> wrap, result=0 at k+17.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid with new operands -> result/carry_out stable, in_ready=0, pulses ignored. Raise out_ready -> IDLE, then next op (55+17) returns 72.
- Assert rst for 1 cycle at ADD bit 3 of 200+100 -> out_valid, busy, result immediately 0 and in_ready=1. Subsequent 55+17 mode 0 returns 72 with nominal latency.
- WIDTH=13, mode 1, a=8000, b=500 -> result=309 (8500 mod 8191), out_valid after edge k+27. a=8191, b=0 -> result=0 at k+14.
